mainfsm: RTL and testbench
==========================

Name: mainfsm

Overview:
Multi-cycle main control state machine for the ARM-subset processor. It sequences fetch, decode, memory, data-processing and branch steps. It produces Moore control strobes and mux selects for the datapath. Its NextPC/RegW/MemW/Branch outputs feed the conditional-write logic, which gates them with the registered condition result. It also keeps a retired-instruction counter for performance monitoring.

Parameters:
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; state forced to FETCH, counter cleared
Op  input  2  instruction bits [27:26]
Funct  input  6  instruction bits [25:20]; Funct[5]=I, Funct[0]=L (memory) / S
IRWrite  output  1  instruction register load enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUResult register
ALUSrcA  output  1  0=register A, 1=PC
ALUSrcB  output  2  00=register WriteData, 01=ExtImm, 10=constant 4
ResultSrc  output  2  00=ALUOut, 01=Data register, 10=ALUResult (direct)
ALUOp  output  1  1=ALU decoder uses Funct, 0=force ADD
NextPC  output  1  unconditional PC write request
RegW  output  1  register-write request (pre-condition)
MemW  output  1  memory-write request (pre-condition)
Branch  output  1  conditional PC write request
instret  output  CNT_W  instructions retired since reset

Behaviour:
- State register: 4 bits, reset value FETCH. Moore outputs are decoded from the current state only. Unlisted outputs are 0, never X.
- While reset=1: NextPC, IRWrite, RegW, MemW and Branch are forced to 0, and instret=0.
- Per-state outputs (selects listed; strobes=1 only where named):
  - FETCH: IRWrite, NextPC; AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0
  - MEMREAD: AdrSrc=1, ResultSrc=00
  - MEMWB: RegW; ResultSrc=01
  - MEMWRITE: MemW; AdrSrc=1, ResultSrc=00
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1
  - ALUWB: RegW; ResultSrc=00
  - BRANCH: Branch; ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0
  - UNKNOWN: all outputs 0
- Transitions:
  - FETCH->DECODE
  - DECODE: Op=00 goes to EXECUTEI if Funct[5]=1, else EXECUTER. Op=01->MEMADR. Op=10->BRANCH. Op=11->UNKNOWN.
  - MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE
  - MEMREAD->MEMWB
  - EXECUTER/EXECUTEI->ALUWB
  - MEMWB, MEMWRITE, ALUWB, BRANCH, UNKNOWN->FETCH
  - Any illegal encoding->FETCH next cycle, outputs 0 meanwhile.
- Op/Funct are sampled every cycle; the IR holds them stable after FETCH. Changes outside DECODE/MEMADR have no effect.
- Cycle counts: LDR 5, STR 4, data-processing 4, B 3, undefined 3.
- instret increments by 1 on each cycle leaving MEMWB, MEMWRITE, ALUWB or BRANCH. UNKNOWN does not count. Instructions that fail their condition still count. The counter wraps modulo 2^CNT_W.
- Reset asserted mid-instruction: the next state is FETCH regardless of current state; no partial retirement is counted.

Decomposition:
- Shared package/header holds the state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
- The same package holds the ALUSrcB and ResultSrc select constants, shared with the datapath muxes.
- State register uses the existing flopr; instret uses flopr with increment logic.
- No other sub-module.

Test Plan:
- Reset held 2 cycles, then released -> state FETCH, IRWrite=1, NextPC=1, instret=0; all strobes 0 during reset.
- Op=01, Funct=011001 (LDR) -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegW=1 only in MEMWB, ResultSrc=01 there; instret 0->1.
- Op=01, Funct=011000 (STR) -> FETCH, DECODE, MEMADR, MEMWRITE, FETCH; MemW=1 and AdrSrc=1 in MEMWRITE only.
- Op=00, Funct=101000, then 001000 -> EXECUTEI with ALUSrcB=01, then EXECUTER with ALUSrcB=00; ALUOp=1 in both; ALUWB RegW=1.
- Op=10 -> BRANCH with Branch=1, ALUSrcB=01, ResultSrc=10; back to FETCH; Op=11 -> UNKNOWN, all outputs 0, instret unchanged.
- Reset asserted in MEMREAD -> FETCH next cycle, instret=0; CNT_W=4 with 16 retirements -> instret wraps to 0.

Source files
------------

// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multi-cycle main controller: state codes and the
// datapath mux select constants used by both the controller and the muxes.
package mainfsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } statetype;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // The final state of every architecturally completed instruction.
    function automatic logic retires(statetype s);
        return (s == MEMWB) || (s == MEMWRITE) || (s == ALUWB) || (s == BRANCH);
    endfunction

endpackage

// File: rtl/mainfsm_if.sv
// Controller-to-datapath bundle: instruction fields in, control strobes and
// mux selects out. master is the controller side, slave the datapath side.
interface mainfsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;

    modport master (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch
    );

    modport slave (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch
    );
endinterface

// File: rtl/mainfsm_flopr.sv
// Resettable register: synchronous active-high reset clears to zero.
module mainfsm_flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end
endmodule

// File: rtl/mainfsm.sv
// Multi-cycle main controller: Moore control strobes and mux selects decoded
// from the current state, plus a retired-instruction counter.
module mainfsm
    import mainfsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mainfsm_if.master        bus,
    output logic [CNT_W-1:0] instret
);

    logic [3:0] state_q;
    statetype   state;
    statetype   next_state;

    logic       ir_write, adr_src, alu_src_a, alu_op;
    logic       next_pc, reg_w, mem_w, branch;
    logic [1:0] alu_src_b, result_src;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic unused_funct;
    assign unused_funct = ^bus.Funct[4:1];

    // Reset value zero is the FETCH encoding.
    mainfsm_flopr #(.WIDTH(4)) state_reg (
        .clk   (clk),
        .reset (reset),
        .d     (next_state),
        .q     (state_q)
    );

    assign state = statetype'(state_q);

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_DP:   next_state = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:  next_state = MEMADR;
                    OP_BR:   next_state = BRANCH;
                    default: next_state = UNKNOWN;
                endcase
            end
            MEMADR:   next_state = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    // Illegal encodings fall into the default arm with every output low.
    always_comb begin
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_WD;
        result_src = RES_ALUOUT;
        alu_op     = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            MEMADR:   alu_src_b = SRCB_IMM;
            MEMREAD:  adr_src   = 1'b1;
            MEMWB: begin
                reg_w      = 1'b1;
                result_src = RES_DATA;
            end
            MEMWRITE: begin
                mem_w   = 1'b1;
                adr_src = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
            end
            ALUWB:    reg_w = 1'b1;
            BRANCH: begin
                branch     = 1'b1;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so nothing is requested before the state settles.
    assign bus.IRWrite   = ir_write & ~reset;
    assign bus.NextPC    = next_pc  & ~reset;
    assign bus.RegW      = reg_w    & ~reset;
    assign bus.MemW      = mem_w    & ~reset;
    assign bus.Branch    = branch   & ~reset;
    assign bus.AdrSrc    = adr_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ResultSrc = result_src;
    assign bus.ALUOp     = alu_op;

    assign count_d = count_q + CNT_W'(retires(state));

    mainfsm_flopr #(.WIDTH(CNT_W)) instret_reg (
        .clk   (clk),
        .reset (reset),
        .d     (count_d),
        .q     (count_q)
    );

    assign instret = reset ? '0 : count_q;

endmodule

// File: tb/tb_mainfsm.sv
// Directed bench for the main controller: per-cycle output patterns for each
// instruction class, reset behaviour and counter wrap on a 4-bit instance.
module tb_mainfsm;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                   S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                   S_ALUWB = 8, S_BRANCH = 9, S_UNKNOWN = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instret;
    logic [3:0]  instret2;
    int          errors = 0;
    int          checks = 0;
    int          exp_ret = 0;

    mainfsm_if ifc ();
    mainfsm_if ifc2 ();

    mainfsm #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(ifc), .instret(instret));
    mainfsm #(.CNT_W(4)) dut2 (.clk(clk), .reset(reset), .bus(ifc2), .instret(instret2));

    always #5 clk = ~clk;

    // Bit order: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc ALUOp NextPC RegW MemW Branch
    function automatic logic [11:0] outs();
        return {ifc.IRWrite, ifc.AdrSrc, ifc.ALUSrcA, ifc.ALUSrcB, ifc.ResultSrc,
                ifc.ALUOp, ifc.NextPC, ifc.RegW, ifc.MemW, ifc.Branch};
    endfunction

    function automatic logic [4:0] strobes();
        return {ifc.IRWrite, ifc.NextPC, ifc.RegW, ifc.MemW, ifc.Branch};
    endfunction

    function automatic logic [11:0] exp_out(int s);
        case (s)
            S_FETCH:    return 12'b1011_0100_1000;
            S_DECODE:   return 12'b0011_0100_0000;
            S_MEMADR:   return 12'b0000_1000_0000;
            S_MEMREAD:  return 12'b0100_0000_0000;
            S_MEMWB:    return 12'b0000_0010_0100;
            S_MEMWRITE: return 12'b0100_0000_0010;
            S_EXECR:    return 12'b0000_0001_0000;
            S_EXECI:    return 12'b0000_1001_0000;
            S_ALUWB:    return 12'b0000_0000_0100;
            S_BRANCH:   return 12'b0000_1100_0001;
            default:    return 12'b0;
        endcase
    endfunction

    task automatic set_instr(input logic [1:0] op, input logic [5:0] funct);
        ifc.Op = op;  ifc.Funct = funct;
        ifc2.Op = op; ifc2.Funct = funct;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_instr(2'b00, 6'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (strobes() !== 5'b0) begin
                errors++;
                $display("FAIL reset_strobes cycle %0d: got %b expected 00000", i, strobes());
            end
            checks++;
            if (instret !== 32'd0) begin
                errors++;
                $display("FAIL reset_instret cycle %0d: got %0d expected 0", i, instret);
            end
        end
        reset = 1'b0;
        exp_ret = 0;
        #1;
        checks++;
        if (outs() !== exp_out(S_FETCH)) begin
            errors++;
            $display("FAIL reset_fetch: got %b expected %b", outs(), exp_out(S_FETCH));
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_release_instret: got %0d expected 0", instret);
        end
    endtask

    task automatic test_ldr();
        int seq [6];
        seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_FETCH};
        set_instr(2'b01, 6'b011001);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            // Op change after MEMADR must not disturb the sequence.
            if (i == 3) set_instr(2'b11, 6'b000000);
            #1;
            checks++;
            if (outs() !== exp_out(seq[i])) begin
                errors++;
                $display("FAIL ldr_outs step %0d: got %b expected %b", i, outs(), exp_out(seq[i]));
            end
            if (i == 4) begin
                checks++;
                if (instret !== 32'(exp_ret)) begin
                    errors++;
                    $display("FAIL ldr_instret_before: got %0d expected %0d", instret, exp_ret);
                end
            end
        end
        exp_ret++;
        checks++;
        if (instret !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL ldr_instret_after: got %0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_str();
        int seq [5];
        seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH};
        set_instr(2'b01, 6'b011000);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (outs() !== exp_out(seq[i])) begin
                errors++;
                $display("FAIL str_outs step %0d: got %b expected %b", i, outs(), exp_out(seq[i]));
            end
        end
        exp_ret++;
        checks++;
        if (instret !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL str_instret: got %0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_data_proc();
        int seq_i [4];
        int seq_r [4];
        seq_i = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB};
        seq_r = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
        set_instr(2'b00, 6'b101000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (outs() !== exp_out(seq_i[i])) begin
                errors++;
                $display("FAIL dp_imm_outs step %0d: got %b expected %b", i, outs(), exp_out(seq_i[i]));
            end
        end
        @(negedge clk);
        set_instr(2'b00, 6'b001000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (outs() !== exp_out(seq_r[i])) begin
                errors++;
                $display("FAIL dp_reg_outs step %0d: got %b expected %b", i, outs(), exp_out(seq_r[i]));
            end
        end
        @(negedge clk);
        exp_ret += 2;
        checks++;
        if (instret !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL dp_instret: got %0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_branch_unknown();
        int seq_b [4];
        int seq_u [4];
        seq_b = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        seq_u = '{S_FETCH, S_DECODE, S_UNKNOWN, S_FETCH};
        set_instr(2'b10, 6'b000000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (outs() !== exp_out(seq_b[i])) begin
                errors++;
                $display("FAIL branch_outs step %0d: got %b expected %b", i, outs(), exp_out(seq_b[i]));
            end
        end
        exp_ret++;
        checks++;
        if (instret !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL branch_instret: got %0d expected %0d", instret, exp_ret);
        end
        set_instr(2'b11, 6'b111111);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (outs() !== exp_out(seq_u[i])) begin
                errors++;
                $display("FAIL unknown_outs step %0d: got %b expected %b", i, outs(), exp_out(seq_u[i]));
            end
        end
        checks++;
        if (instret !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL unknown_instret: got %0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_reset_mid();
        int seq [5];
        seq = '{S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_FETCH};
        set_instr(2'b01, 6'b011001);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (strobes() !== 5'b0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL midreset_during: strobes %b instret %0d expected 00000 and 0", strobes(), instret);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_ret = 0;
        #1;
        checks++;
        if (outs() !== exp_out(S_FETCH)) begin
            errors++;
            $display("FAIL midreset_fetch: got %b expected %b", outs(), exp_out(S_FETCH));
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++;
            $display("FAIL midreset_instret: got %0d expected 0", instret);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== exp_out(seq[i])) begin
                errors++;
                $display("FAIL midreset_rerun step %0d: got %b expected %b", i, outs(), exp_out(seq[i]));
            end
        end
        exp_ret = 1;
        checks++;
        if (instret !== 32'(exp_ret)) begin
            errors++;
            $display("FAIL midreset_retire: got %0d expected %0d", instret, exp_ret);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp4;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_ret = 0;
        set_instr(2'b10, 6'b000000);
        for (int k = 0; k < 16; k++) begin
            repeat (3) @(negedge clk);
            exp_ret++;
            exp4 = 4'(exp_ret % 16);
            if (k == 14 || k == 15) begin
                checks++;
                if (instret2 !== exp4) begin
                    errors++;
                    $display("FAIL wrap_cnt4 after %0d: got %0d expected %0d", k + 1, instret2, exp4);
                end
            end
        end
        checks++;
        if (instret !== 32'd16) begin
            errors++;
            $display("FAIL wrap_cnt32: got %0d expected 16", instret);
        end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_str();
        test_data_proc();
        test_branch_unknown();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
